// File: rtl/sweep_register_file.sv
// Register file with a hardwired-zero entry, per-register pending-write (busy) flags and a
// self-clearing sweep after reset or ClrReq. Define REGFILE_BYPASS_EN to forward BusW to same-cycle reads.
module sweep_register_file #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 2**ADDR_W-1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  output logic [DATA_W-1:0] BusA,
  output logic [DATA_W-1:0] BusB,
  output logic              BusyA,
  output logic              BusyB,
  input  logic [ADDR_W-1:0] RW,
  input  logic [DATA_W-1:0] BusW,
  input  logic              RegWr,
  input  logic              RsvEn,
  input  logic [ADDR_W-1:0] RsvReg,
  input  logic              ClrReq,
  output logic              Ready
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_ok;
  logic              rsv_ok;

  assign wr_ok  = (state == READY) && RegWr && (RW != ZERO_IDX);
  assign rsv_ok = (state == READY) && RsvEn && (RsvReg != ZERO_IDX);

  // Reserve is applied after the write-clear so a same-register reserve wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)  busy_nxt[RW]     = 1'b0;
    if (rsv_ok) busy_nxt[RsvReg] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= '0;
      Ready <= 1'b0;
    end else if (ClrReq) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= '0;
      Ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (cnt == LAST_IDX) begin
            state <= READY;
            Ready <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        READY: busy <= busy_nxt;
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage has no reset; the sweep zeroes one entry per cycle instead.
  always_ff @(posedge Clk) begin
    if (state == CLEAR)
      regs[cnt] <= '0;
    else if (wr_ok)
      regs[RW] <= BusW;
  end

  always_comb begin
    BusA  = '0;
    BusB  = '0;
    BusyA = 1'b0;
    BusyB = 1'b0;
    if (state == READY) begin
      if (RA != ZERO_IDX) BusA = regs[RA];
      if (RB != ZERO_IDX) BusB = regs[RB];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (RW == RA)) BusA = BusW;
      if (wr_ok && (RW == RB)) BusB = BusW;
`endif
      BusyA = busy[RA];
      BusyB = busy[RB];
    end
  end

endmodule

// File: tb/tb_sweep_register_file.sv
// Directed bench for sweep_register_file: sweep timing, reads/writes, busy flags, ClrReq and async reset.
module tb_sweep_register_file;
  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [4:0]  RA, RB, RW, RsvReg;
  logic [63:0] BusA, BusB, BusW;
  logic        BusyA, BusyB, RegWr, RsvEn, ClrReq, Ready;

  logic [63:0] exp_q[$];
  string       tag_q[$];
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;
  int          n;

  sweep_register_file dut (
    .Clk(Clk), .Rst_n(Rst_n), .RA(RA), .RB(RB), .BusA(BusA), .BusB(BusB),
    .BusyA(BusyA), .BusyB(BusyB), .RW(RW), .BusW(BusW), .RegWr(RegWr),
    .RsvEn(RsvEn), .RsvReg(RsvReg), .ClrReq(ClrReq), .Ready(Ready)
  );

  always #5 Clk = ~Clk;

  task automatic push_exp(input string tag, input logic [63:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic pop_cmp(input logic [63:0] obs);
    logic [63:0] e;
    string t;
    total++;
    if (exp_q.size() == 0) begin
      failed++;
      $error("FAIL scoreboard_empty observed=%h", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (Ready !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    RW = a; BusW = d; RegWr = 1'b1;
    tick();
    RegWr = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0; RA = '0; RB = '0; RW = '0; RsvReg = '0; BusW = '0;
    RegWr = 1'b0; RsvEn = 1'b0; ClrReq = 1'b0;
    tick(); tick();
    push_exp("reset_ready", 64'd0); pop_cmp({63'd0, Ready});

    // Initial sweep: 32 cycles of Ready low, then everything reads zero
    Rst_n = 1'b1;
    wait_ready(n);
    push_exp("sweep_cycles", 64'd32); pop_cmp(64'(n));
    for (int i = 0; i < 32; i++) begin
      RA = 5'(i); RB = 5'(31 - i);
      settle();
      push_exp("sweep_zero_a", 64'd0); pop_cmp(BusA);
      push_exp("sweep_zero_b", 64'd0); pop_cmp(BusB);
    end

    // Basic write/read and the zero register
    RA = 5'd3;
    push_exp("write_reg3", 64'hDEAD_BEEF);
    wr(5'd3, 64'hDEAD_BEEF);
    settle(); pop_cmp(BusA);
    RA = 5'd31;
    wr(5'd31, 64'h1);
    settle();
    push_exp("zero_reg_read", 64'd0); pop_cmp(BusA);
    RsvEn = 1'b1; RsvReg = 5'd31; tick(); RsvEn = 1'b0;
    settle();
    push_exp("zero_reg_busy", 64'd0); pop_cmp({63'd0, BusyA});

    // Same-cycle read of a register being written
    wr(5'd7, 64'h11);
    RA = 5'd7; RW = 5'd7; BusW = 64'hA5; RegWr = 1'b1;
    settle();
`ifdef REGFILE_BYPASS_EN
    push_exp("bypass_same_cycle", 64'hA5);
`else
    push_exp("no_bypass_old_value", 64'h11);
`endif
    pop_cmp(BusA);
    tick(); RegWr = 1'b0; settle();
    push_exp("after_write_edge", 64'hA5); pop_cmp(BusA);
    RA = 5'd31; RW = 5'd31; BusW = 64'hFF; RegWr = 1'b1;
    settle();
    push_exp("zero_reg_no_bypass", 64'd0); pop_cmp(BusA);
    tick(); RegWr = 1'b0;

    // Busy flags: reserve, write clears, reserve+write keeps busy
    RsvEn = 1'b1; RsvReg = 5'd5; tick(); RsvEn = 1'b0;
    RA = 5'd5; RB = 5'd5; settle();
    push_exp("busy_after_rsv_a", 64'd1); pop_cmp({63'd0, BusyA});
    push_exp("busy_after_rsv_b", 64'd1); pop_cmp({63'd0, BusyB});
    wr(5'd5, 64'h55); settle();
    push_exp("busy_cleared_by_write", 64'd0); pop_cmp({63'd0, BusyA});
    RsvEn = 1'b1; RsvReg = 5'd5;
    wr(5'd5, 64'h66); RsvEn = 1'b0; settle();
    push_exp("rsv_wins_busy", 64'd1); pop_cmp({63'd0, BusyA});
    push_exp("rsv_wins_data", 64'h66); pop_cmp(BusA);

    // ClrReq: outputs blanked during CLEAR, restart at index 10, writes in CLEAR dropped
    ClrReq = 1'b1; tick(); ClrReq = 1'b0;
    RA = 5'd3; settle();
    push_exp("clear_bus_zero", 64'd0); pop_cmp(BusA);
    push_exp("clear_ready_low", 64'd0); pop_cmp({63'd0, Ready});
    RA = 5'd5; settle();
    push_exp("clear_busy_zero", 64'd0); pop_cmp({63'd0, BusyA});
    for (int i = 0; i < 10; i++) tick();
    ClrReq = 1'b1; tick(); ClrReq = 1'b0;
    RW = 5'd3; BusW = 64'hFFFF; RsvReg = 5'd3;
    n = 0;
    while (Ready !== 1'b1 && n < 200) begin
      RegWr = (n == 10); RsvEn = (n == 10);
      tick();
      n++;
    end
    RegWr = 1'b0; RsvEn = 1'b0;
    push_exp("restart_cycles", 64'd32); pop_cmp(64'(n));
    RA = 5'd3; RB = 5'd5; settle();
    push_exp("clear_write_dropped", 64'd0); pop_cmp(BusA);
    push_exp("clear_rsv_dropped", 64'd0); pop_cmp({63'd0, BusyA});
    push_exp("clear_wiped_reg5", 64'd0); pop_cmp(BusB);

    // Async reset with a pending reservation, then mid-sweep
    RsvEn = 1'b1; RsvReg = 5'd9; tick(); RsvEn = 1'b0;
    RA = 5'd9; settle();
    push_exp("rsv9_busy", 64'd1); pop_cmp({63'd0, BusyA});
    wr(5'd9, 64'h99); RsvEn = 1'b0;
    RsvEn = 1'b1; RsvReg = 5'd9; tick(); RsvEn = 1'b0;
    Rst_n = 1'b0; settle();
    push_exp("rst_ready_now", 64'd0); pop_cmp({63'd0, Ready});
    push_exp("rst_busy_now", 64'd0); pop_cmp({63'd0, dut.busy != '0});
    Rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    Rst_n = 1'b0; settle();
    push_exp("rst_mid_sweep_ready", 64'd0); pop_cmp({63'd0, Ready});
    Rst_n = 1'b1;
    wait_ready(n);
    push_exp("rst_resweep_cycles", 64'd32); pop_cmp(64'(n));
    RA = 5'd9; RB = 5'd7; settle();
    push_exp("rst_reg9_zero", 64'd0); pop_cmp(BusA);
    push_exp("rst_reg9_not_busy", 64'd0); pop_cmp({63'd0, BusyA});
    push_exp("rst_reg7_zero", 64'd0); pop_cmp(BusB);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
